// File: rtl/ifu_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: enable levels,
// FSM state encoding, default NOP and the jump-target alignment helper.
package ifu_fetch_pkg;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0013;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_WAIT = 3'd2,
    ST_DROP = 3'd3,
    ST_OUT  = 3'd4
  } state_e;

  // Fetch addresses are always word aligned.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the PC, issues one outstanding fetch at a
// time and presents the fetched instruction to IF/ID with valid/ready.
// A jump redirects the PC and discards any old-path instruction.
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = NOP_INST_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cu2pc_jump_en_i,
  input  logic [31:0] ex2pc_jump_addr_i,
  output logic        ifu2mem_req_o,
  output logic [31:0] ifu2mem_addr_o,
  input  logic        mem2ifu_gnt_i,
  input  logic        mem2ifu_rvalid_i,
  input  logic [31:0] mem2ifu_rdata_i,
  output logic        ifu2id_valid_o,
  output logic [31:0] ifu2id_pc_o,
  output logic [31:0] ifu2id_inst_o,
  input  logic        id2ifu_ready_i
);

  state_e      state_q,    state_d;
  logic [31:0] pc_q,       pc_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic        valid_q,    valid_d;
  logic [31:0] out_pc_q,   out_pc_d;
  logic [31:0] inst_q,     inst_d;

  logic        jump;
  logic [31:0] target;

  // Next-state logic. A jump always reloads the PC; the state case only
  // decides where the FSM goes and whether old-path data is kept.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    fetch_pc_d = fetch_pc_q;
    valid_d    = valid_q;
    out_pc_d   = out_pc_q;
    inst_d     = inst_q;

    jump   = (cu2pc_jump_en_i == ENABLE);
    target = align_word(ex2pc_jump_addr_i);

    if (jump) begin
      pc_d = target;
    end

    unique case (state_q)
      ST_IDLE: begin
        state_d = ST_REQ;
      end
      ST_REQ: begin
        if (mem2ifu_gnt_i) begin
          if (jump) begin
            // Granted request belongs to the old path: wait out its response.
            state_d = ST_DROP;
          end else begin
            fetch_pc_d = pc_q;
            pc_d       = pc_q + 32'd4;
            state_d    = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (jump) begin
          state_d = mem2ifu_rvalid_i ? ST_REQ : ST_DROP;
        end else if (mem2ifu_rvalid_i) begin
          valid_d  = 1'b1;
          out_pc_d = fetch_pc_q;
          inst_d   = mem2ifu_rdata_i;
          state_d  = ST_OUT;
        end
      end
      ST_DROP: begin
        if (mem2ifu_rvalid_i) begin
          state_d = ST_REQ;
        end
      end
      ST_OUT: begin
        // A jump cancels the hand-over even if ready is high.
        if (jump || id2ifu_ready_i) begin
          valid_d = 1'b0;
          inst_d  = NOP_INST;
          state_d = ST_REQ;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, PC and IF/ID output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_PC;
      fetch_pc_q <= RESET_PC;
      valid_q    <= 1'b0;
      out_pc_q   <= '0;
      inst_q     <= NOP_INST;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      fetch_pc_q <= fetch_pc_d;
      valid_q    <= valid_d;
      out_pc_q   <= out_pc_d;
      inst_q     <= inst_d;
    end
  end

  assign ifu2mem_req_o  = (state_q == ST_REQ);
  assign ifu2mem_addr_o = pc_q;
  assign ifu2id_valid_o = valid_q;
  assign ifu2id_pc_o    = out_pc_q;
  assign ifu2id_inst_o  = inst_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// Scoreboard bench for ifu_fetch: a memory/driver process issues grants,
// responses, ready and jumps; a monitor checks every delivered instruction
// against the expected program-order stream.
module tb_ifu_fetch;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        jump_en;
  logic [31:0] jump_addr;
  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        valid;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic        ready;

  ifu_fetch #(
    .RESET_PC(RST_PC),
    .NOP_INST(NOP)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .cu2pc_jump_en_i   (jump_en),
    .ex2pc_jump_addr_i (jump_addr),
    .ifu2mem_req_o     (req),
    .ifu2mem_addr_o    (addr),
    .mem2ifu_gnt_i     (gnt),
    .mem2ifu_rvalid_i  (rvalid),
    .mem2ifu_rdata_i   (rdata),
    .ifu2id_valid_o    (valid),
    .ifu2id_pc_o       (pc_o),
    .ifu2id_inst_o     (inst_o),
    .id2ifu_ready_i    (ready)
  );

  initial forever #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  // Stimulus knobs.
  int          gnt_pct   = 100;
  int          ready_pct = 100;
  int          jump_pct  = 0;
  int          dmin      = 1;
  int          dmax      = 1;
  int          jump_mode = 0; // 1 on grant, 2 in wait, 3 with rvalid, 4 in out
  logic [31:0] jtgt      = '0;
  int          fired     = 0;
  int          delivered = 0;

  // Expected PCs of future hand-overs, in program order.
  logic [31:0] exp_q[$];

  function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endfunction

  // Instruction memory contents.
  function automatic logic [31:0] memf(input logic [31:0] a);
    if (a == 32'h0) return 32'h0010_0093;
    return ({a[15:0], a[31:16]} ^ 32'hC3A5_9617) + a;
  endfunction

  task automatic fire(input logic [31:0] t);
    jump_en   = 1'b1;
    jump_addr = t;
    exp_q.delete();
    exp_q.push_back(t & 32'hFFFF_FFFC);
    jump_mode = 0;
    fired++;
  endtask

  // Memory, IF/ID consumer and control-unit driver, acting on falling edges.
  initial begin : driver
    bit          pend;
    int          cnt;
    logic [31:0] pend_addr;
    bit          did;
    pend = 1'b0;
    cnt = 0;
    pend_addr = '0;
    forever begin
      @(negedge clk);
      gnt     = 1'b0;
      rvalid  = 1'b0;
      jump_en = 1'b0;
      if (rst) begin
        pend  = 1'b0;
        ready = 1'b0;
        continue;
      end
      jump_addr = $urandom;
      did = 1'b0;
      if (pend) begin
        cnt--;
        if (cnt == 0) begin
          rvalid = 1'b1;
          rdata  = memf(pend_addr);
          pend   = 1'b0;
          if (jump_mode == 3) begin fire(jtgt); did = 1'b1; end
        end
      end
      ready = ($urandom_range(0, 99) < ready_pct);
      if (req && ($urandom_range(0, 99) < gnt_pct)) begin
        gnt       = 1'b1;
        pend      = 1'b1;
        pend_addr = addr;
        cnt       = $urandom_range(dmax, dmin);
        if (jump_mode == 1) begin fire(jtgt); did = 1'b1; end
      end
      if (!did && jump_mode == 2 && pend && !gnt) begin fire(jtgt); did = 1'b1; end
      if (!did && jump_mode == 4 && valid && ready) begin fire(jtgt); did = 1'b1; end
      if (!did && jump_pct > 0 && $urandom_range(0, 99) < jump_pct) fire($urandom);
    end
  end

  // Monitor: checks each hand-over against the scoreboard and the
  // output-register invariants, sampling 1 ns after the rising edge.
  initial begin : monitor
    logic        pv;
    logic [31:0] ppc, pinst, e;
    pv = 1'b0;
    ppc = '0;
    pinst = '0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        exp_q.delete();
        exp_q.push_back(RST_PC);
      end else begin
        if (pv && ready && !jump_en) begin
          if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            chk("deliver_pc", ppc, e);
            chk("deliver_inst", pinst, memf(e));
            exp_q.push_back(e + 32'd4);
            delivered++;
          end
          chk("valid_drop_after_accept", {31'b0, valid}, 32'd0);
        end else if (pv && jump_en) begin
          chk("valid_drop_on_jump", {31'b0, valid}, 32'd0);
        end else if (pv) begin
          chk("stall_valid", {31'b0, valid}, 32'd1);
          chk("stall_pc", pc_o, ppc);
          chk("stall_inst", inst_o, pinst);
        end
        if (!valid) chk("nop_when_invalid", inst_o, NOP);
        if (req) chk("addr_aligned", {30'b0, addr[1:0]}, 32'd0);
      end
      pv    = valid;
      ppc   = pc_o;
      pinst = inst_o;
    end
  end

  task automatic sample();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(output logic [31:0] a, output int n, output bit sv);
    n = 0;
    sv = 1'b0;
    while (!req && n < 200) begin
      if (valid) sv = 1'b1;
      sample();
      n++;
    end
    if (!req) chk("wait_req_timeout", 32'd1, 32'd0);
    a = addr;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!valid && n < 200) begin
      sample();
      n++;
    end
    if (!valid) chk("wait_valid_timeout", 32'd1, 32'd0);
  endtask

  task automatic wait_fired(input int f0);
    int n;
    n = 0;
    while (fired == f0 && n < 100) begin
      sample();
      n++;
    end
    if (fired == f0) chk("jump_fire_timeout", 32'd1, 32'd0);
  endtask

  initial begin : main
    logic [31:0] a, hpc, hinst;
    int n, f0, d0;
    bit sv;
    rst = 1'b1;
    jump_en = 1'b0;
    jump_addr = '0;
    gnt = 1'b0;
    rvalid = 1'b0;
    rdata = '0;
    ready = 1'b0;

    #2;
    chk("rst_req", {31'b0, req}, 32'd0);
    chk("rst_addr", addr, RST_PC);
    chk("rst_valid", {31'b0, valid}, 32'd0);
    chk("rst_pc", pc_o, 32'd0);
    chk("rst_inst", inst_o, NOP);

    // Zero-wait memory, ready high.
    repeat (2) @(negedge clk);
    rst = 1'b0;
    sample();
    wait_req(a, n, sv);
    chk("first_req_cycle", n, 0);
    chk("first_req_addr", a, 32'h0);
    wait_valid(n);
    chk("first_latency", n, 2);
    chk("first_pc", pc_o, 32'h0);
    chk("first_inst", inst_o, 32'h0010_0093);
    sample();
    wait_req(a, n, sv);
    chk("second_req_addr", a, 32'h4);

    // Stall in OUT for 5 cycles, accept on the 6th.
    ready_pct = 0;
    wait_valid(n);
    hpc = pc_o;
    hinst = inst_o;
    chk("stall_start_pc", hpc, 32'h4);
    for (int i = 0; i < 5; i++) begin
      sample();
      chk("hold_valid", {31'b0, valid}, 32'd1);
      chk("hold_pc", pc_o, hpc);
      chk("hold_inst", inst_o, hinst);
      chk("hold_no_req", {31'b0, req}, 32'd0);
    end
    ready_pct = 100;
    sample();
    chk("accept_valid_drop", {31'b0, valid}, 32'd0);
    chk("accept_req", {31'b0, req}, 32'd1);
    chk("accept_next_addr", addr, hpc + 32'd4);

    // Jump in WAIT before the response for 0x8.
    dmin = 3; dmax = 3;
    f0 = fired; jtgt = 32'h0000_0102; jump_mode = 2;
    wait_fired(f0);
    wait_req(a, n, sv);
    chk("wait_jump_no_valid", {31'b0, sv}, 32'd0);
    chk("wait_jump_req", a, 32'h100);
    dmin = 1; dmax = 1;
    wait_valid(n);
    chk("wait_jump_pc", pc_o, 32'h100);
    sample();
    wait_req(a, n, sv);

    // Jump together with the grant.
    f0 = fired; jtgt = 32'h0000_0200; jump_mode = 1;
    wait_fired(f0);
    wait_req(a, n, sv);
    chk("gnt_jump_no_valid", {31'b0, sv}, 32'd0);
    chk("gnt_jump_req", a, 32'h200);
    wait_valid(n);
    chk("gnt_jump_pc", pc_o, 32'h200);
    sample();
    wait_req(a, n, sv);

    // Jump together with rvalid.
    f0 = fired; jtgt = 32'h0000_0300; jump_mode = 3;
    wait_fired(f0);
    wait_req(a, n, sv);
    chk("rvalid_jump_immediate", n, 0);
    chk("rvalid_jump_req", a, 32'h300);
    wait_valid(n);
    chk("rvalid_jump_pc", pc_o, 32'h300);
    sample();
    wait_req(a, n, sv);

    // Jump while OUT with ready high.
    d0 = delivered;
    f0 = fired; jtgt = 32'h0000_0400; jump_mode = 4;
    wait_fired(f0);
    chk("out_jump_valid", {31'b0, valid}, 32'd0);
    chk("out_jump_req", {31'b0, req}, 32'd1);
    chk("out_jump_addr", addr, 32'h400);
    chk("out_jump_no_handshake", delivered, d0);
    wait_valid(n);
    chk("out_jump_pc", pc_o, 32'h400);
    sample();
    wait_req(a, n, sv);

    // Unaligned target at the top of memory, then wrap.
    f0 = fired; jtgt = 32'hFFFF_FFFF; jump_mode = 3;
    wait_fired(f0);
    wait_req(a, n, sv);
    chk("top_req", a, 32'hFFFF_FFFC);
    wait_valid(n);
    chk("top_pc", pc_o, 32'hFFFF_FFFC);
    sample();
    wait_req(a, n, sv);
    chk("wrap_req", a, 32'h0);
    wait_valid(n);
    sample();
    wait_req(a, n, sv);
    chk("post_wrap_req", a, 32'h4);

    // Asynchronous reset while waiting for a response.
    dmin = 3; dmax = 3;
    sample();
    chk("in_wait_no_req", {31'b0, req}, 32'd0);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", {31'b0, valid}, 32'd0);
    chk("arst_pc", pc_o, 32'd0);
    chk("arst_inst", inst_o, NOP);
    chk("arst_req", {31'b0, req}, 32'd0);
    chk("arst_addr", addr, RST_PC);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    dmin = 1; dmax = 1;
    sample();
    wait_req(a, n, sv);
    chk("arst_restart_cycle", n, 0);
    chk("arst_restart_addr", a, RST_PC);

    // Randomized traffic.
    gnt_pct = 60; ready_pct = 70; jump_pct = 4; dmin = 1; dmax = 4;
    d0 = delivered;
    repeat (3000) sample();
    chk("random_progress", {31'b0, (delivered - d0) > 20}, 32'd1);
    jump_pct = 0;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
